// File: rtl/c_arb_merge_n.sv
// rtl/c_arb_merge_n.sv - N-channel arbitrated click merge; CARB_MERGE_RR_EN selects round-robin arbitration
`timescale 1ns/1ps
module c_arb_merge_n #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                                  w_rstStartflag,
    input  logic [NUM_CH-1:0]                     i_drive,
    output logic [NUM_CH-1:0]                     o_free,
    input  logic [NUM_CH*(DATA_W>0?DATA_W:1)-1:0] i_data,
    output logic                                  o_driveNext,
    input  logic                                  i_freeNext,
    output logic [(DATA_W>0?DATA_W:1)-1:0]        o_data,
    output logic [NUM_CH-1:0]                     o_grant,
    output logic [IDX_W-1:0]                      o_grant_idx,
    output logic                                  o_busy
);
    localparam int DW = (DATA_W > 0) ? DATA_W : 1;

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] r_snap;
    logic [NUM_CH-1:0] w_win_oh;
    logic [IDX_W-1:0]  w_win_idx;
    logic [DW-1:0]     w_win_data;
    logic r_smp_t, r_gnt_t, r_drv_t;
    logic r_idle_clr_t, r_idle_set_t, r_rf_set_t, r_rf_clr_t, r_busy_set_t, r_busy_clr_t;
    logic w_start_flag, w_refire, w_start, w_gnt_fire, w_drv_fire;

    // Pending bit per channel: set by a drive edge, cleared only by that channel's free.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_pend
        logic r_pend;
        always_ff @(posedge i_drive[k] or posedge o_free[k] or negedge w_rstStartflag) begin
            if (!w_rstStartflag)  r_pend <= 1'b0;
            else if (o_free[k])   r_pend <= 1'b0;
            else                  r_pend <= 1'b1;
        end
        assign w_pend[k] = r_pend;
    end

    // Each flag is a set/clear toggle pair so every toggle has exactly one event owner.
    assign w_start_flag = ~(r_idle_clr_t ^ r_idle_set_t);
    assign w_refire     = r_rf_set_t ^ r_rf_clr_t;
    assign o_busy       = r_busy_set_t ^ r_busy_clr_t;
    assign o_driveNext  = o_busy;
    assign o_free       = o_grant & {NUM_CH{i_freeNext}};

    assign w_start    = (w_start_flag & (|w_pend)) | (w_refire & ~i_freeNext);
    assign w_gnt_fire = r_smp_t ^ r_gnt_t;
    assign w_drv_fire = r_gnt_t ^ r_drv_t;

    always_ff @(posedge i_freeNext or negedge w_rstStartflag) begin
        if (!w_rstStartflag) begin
            r_busy_clr_t <= 1'b0;
            r_rf_set_t   <= 1'b0;
        end else if (o_busy) begin
            r_busy_clr_t <= ~r_busy_clr_t;
            r_rf_set_t   <= ~r_rf_set_t;
        end
    end

    always_ff @(posedge w_start or negedge w_rstStartflag) begin
        if (!w_rstStartflag) begin
            r_snap       <= '0;
            r_smp_t      <= 1'b0;
            r_idle_clr_t <= 1'b0;
            r_rf_clr_t   <= 1'b0;
        end else begin
            r_snap  <= w_pend;
            r_smp_t <= ~r_smp_t;
            if (w_start_flag) r_idle_clr_t <= ~r_idle_clr_t;
            if (w_refire)     r_rf_clr_t   <= ~r_rf_clr_t;
        end
    end

`ifdef CARB_MERGE_RR_EN
    logic [IDX_W-1:0] r_ptr;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= NUM_CH) ? IDX_W'(v - NUM_CH) : IDX_W'(v);
    endfunction

    // Scan from farthest to nearest so the first set bit after the pointer is left standing.
    always_comb begin
        w_win_oh  = '0;
        w_win_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (r_snap[wrap_idx(int'(r_ptr) + i)]) begin
                w_win_oh                            = '0;
                w_win_oh[wrap_idx(int'(r_ptr) + i)] = 1'b1;
                w_win_idx                           = wrap_idx(int'(r_ptr) + i);
            end
        end
    end
`else
    always_comb begin
        w_win_oh  = '0;
        w_win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_snap[i]) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_win_data = '0;
        if (DATA_W > 0 && |r_snap) w_win_data = i_data[int'(w_win_idx)*DW +: DW];
    end

    always_ff @(posedge w_gnt_fire or negedge w_rstStartflag) begin
        if (!w_rstStartflag) begin
            r_gnt_t     <= 1'b0;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_data      <= '0;
`ifdef CARB_MERGE_RR_EN
            r_ptr       <= IDX_W'(NUM_CH - 1);
`endif
        end else begin
            r_gnt_t     <= ~r_gnt_t;
            o_grant     <= w_win_oh;
            o_grant_idx <= w_win_idx;
            o_data      <= w_win_data;
`ifdef CARB_MERGE_RR_EN
            if (|r_snap) r_ptr <= w_win_idx;
`endif
        end
    end

    // Runs one event after the grant so downstream sees a settled grant and payload.
    always_ff @(posedge w_drv_fire or negedge w_rstStartflag) begin
        if (!w_rstStartflag) begin
            r_drv_t      <= 1'b0;
            r_busy_set_t <= 1'b0;
            r_idle_set_t <= 1'b0;
        end else begin
            r_drv_t <= ~r_drv_t;
            if (|o_grant) r_busy_set_t <= ~r_busy_set_t;
            else          r_idle_set_t <= ~r_idle_set_t;
        end
    end
endmodule

// File: tb/tb_c_arb_merge_n.sv
// tb/tb_c_arb_merge_n.sv - randomized self-checking bench for c_arb_merge_n
`timescale 1ns/1ps
module tb_c_arb_merge_n;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;

    logic clk = 1'b0;
    always #1 clk = ~clk;

    logic                     rstn = 1'b0;
    logic [NUM_CH-1:0]        i_drive = '0;
    logic [NUM_CH-1:0]        o_free;
    logic [NUM_CH*DATA_W-1:0] i_data = '0;
    logic                     o_driveNext;
    logic                     i_freeNext = 1'b0;
    logic [DATA_W-1:0]        o_data;
    logic [NUM_CH-1:0]        o_grant;
    logic [IDX_W-1:0]         o_grant_idx;
    logic                     o_busy;

    c_arb_merge_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .w_rstStartflag(rstn), .i_drive(i_drive), .o_free(o_free), .i_data(i_data),
        .o_driveNext(o_driveNext), .i_freeNext(i_freeNext), .o_data(o_data),
        .o_grant(o_grant), .o_grant_idx(o_grant_idx), .o_busy(o_busy));

    int n_checks = 0;
    int n_fail   = 0;

    bit              m_pend[NUM_CH];
    logic [DATA_W-1:0] m_data[NUM_CH];
    int              m_ptr = NUM_CH - 1;
    int              req_cnt[NUM_CH];
    int              free_cnt[NUM_CH];
    time             t_free[NUM_CH];
    int              drv_cnt = 0;
    time             t_drv = 0;
    logic [NUM_CH-1:0] free_prev = '0;

    always @(posedge o_driveNext) begin
        drv_cnt++;
        t_drv = $time;
    end

    always @(o_free) begin
        for (int k = 0; k < NUM_CH; k++)
            if (o_free[k] && !free_prev[k]) begin
                free_cnt[k]++;
                t_free[k] = $time;
            end
        free_prev = o_free;
    end

    always @(o_grant) begin
        n_checks++;
        if (!$onehot0(o_grant)) begin
            n_fail++;
            $display("FAIL grant_onehot: o_grant=%b is neither one-hot nor zero", o_grant);
        end
    end

    function automatic int exp_winner();
`ifdef CARB_MERGE_RR_EN
        for (int i = 1; i <= NUM_CH; i++) begin
            int c = (m_ptr + i) % NUM_CH;
            if (m_pend[c]) return c;
        end
`else
        for (int i = 0; i < NUM_CH; i++)
            if (m_pend[i]) return i;
`endif
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0] pend_vec();
        logic [NUM_CH-1:0] v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k] = m_pend[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_pend[k] = 1'b0;
        m_ptr = NUM_CH - 1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #6;
        rstn = 1'b1;
        model_reset();
        #4;
    endtask

    task automatic pulse_drive(input logic [NUM_CH-1:0] mask, input int fixed);
        for (int k = 0; k < NUM_CH; k++)
            if (mask[k]) begin
                if (m_pend[k]) $fatal(1, "FAIL protocol: drive on already pending ch%0d", k);
                m_pend[k] = 1'b1;
                m_data[k] = (fixed >= 0) ? DATA_W'(fixed) : DATA_W'($urandom);
                i_data[k*DATA_W +: DATA_W] = m_data[k];
                req_cnt[k]++;
            end
        i_drive = mask;
        #1;
        i_drive = '0;
        #1;
    endtask

    task automatic pulse_free(input int lat, input int g);
        #(lat);
        i_freeNext = 1'b1;
        #2;
        i_freeNext = 1'b0;
        if (g >= 0) m_pend[g] = 1'b0;
        #1;
    endtask

    task automatic wait_drv(input int base, output bit ok);
        int t = 0;
        while (drv_cnt <= base && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (drv_cnt > base);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #5;
        rstn = 1'b1;
        model_reset();
        #4;
        n_checks++; if (o_grant !== '0) begin n_fail++; $display("FAIL rst_grant: got %b want 0", o_grant); end
        n_checks++; if (o_grant_idx !== '0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", o_grant_idx); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", o_data); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        n_checks++; if (o_driveNext !== 1'b0) begin n_fail++; $display("FAIL rst_drive: got %b want 0", o_driveNext); end
        n_checks++; if (o_free !== '0) begin n_fail++; $display("FAIL rst_free: got %b want 0", o_free); end
    endtask

    task automatic test_single();
        int base = drv_cnt;
        int f2 = free_cnt[2];
        bit ok;
        pulse_drive(4'b0100, 8'hA5);
        wait_drv(base, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drive: no o_driveNext seen, want 1"); end
        n_checks++; if (o_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", o_grant); end
        n_checks++; if (o_grant_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", o_grant_idx); end
        n_checks++; if (o_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", o_data); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", o_busy); end
        m_ptr = 2;
        i_freeNext = 1'b1;
        #1;
        n_checks++; if (o_free !== 4'b0100) begin n_fail++; $display("FAIL single_free: got %b want 0100", o_free); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr: got %b want 0", o_busy); end
        i_freeNext = 1'b0;
        m_pend[2] = 1'b0;
        #6;
        n_checks++; if (o_grant !== '0) begin n_fail++; $display("FAIL single_idle: got %b want 0", o_grant); end
        n_checks++; if (drv_cnt !== base + 1) begin n_fail++; $display("FAIL single_drv_count: got %0d want %0d", drv_cnt, base + 1); end
        n_checks++; if (free_cnt[2] !== f2 + 1) begin n_fail++; $display("FAIL single_free_count: got %0d want %0d", free_cnt[2], f2 + 1); end
    endtask

    task automatic test_simultaneous();
        int base = drv_cnt;
        int e1, e2;
        bit ok;
        pulse_drive(4'b1001, -1);
        e1 = exp_winner();
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== NUM_CH'(1) << e1) begin n_fail++; $display("FAIL simul_first: got %b want ch%0d", o_grant, e1); end
        n_checks++; if (o_data !== m_data[e1]) begin n_fail++; $display("FAIL simul_data1: got %h want %h", o_data, m_data[e1]); end
        m_ptr = e1;
        pulse_free(3, e1);
        e2 = exp_winner();
        wait_drv(base + 1, ok);
        n_checks++; if (!ok || o_grant !== NUM_CH'(1) << e2) begin n_fail++; $display("FAIL simul_second: got %b want ch%0d", o_grant, e2); end
        n_checks++; if (!(t_free[e1] < t_drv)) begin n_fail++; $display("FAIL simul_order: free at %0t not before drive at %0t", t_free[e1], t_drv); end
        m_ptr = e2;
        pulse_free(2, e2);
        #5;
        n_checks++; if (drv_cnt !== base + 2) begin n_fail++; $display("FAIL simul_count: got %0d want %0d", drv_cnt, base + 2); end
        n_checks++; if (o_grant !== '0) begin n_fail++; $display("FAIL simul_idle: got %b want 0", o_grant); end
    endtask

    task automatic test_late_arrival();
        int base = drv_cnt;
        int f1 = free_cnt[1];
        int f3 = free_cnt[3];
        bit ok;
        pulse_drive(4'b0010, -1);
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== 4'b0010) begin n_fail++; $display("FAIL late_first: got %b want 0010", o_grant); end
        m_ptr = 1;
        pulse_drive(4'b1000, -1);
        n_checks++; if (drv_cnt !== base + 1) begin n_fail++; $display("FAIL late_no_early: got %0d drives want %0d", drv_cnt, base + 1); end
        pulse_free(4, 1);
        wait_drv(base + 1, ok);
        n_checks++; if (!ok || o_grant !== 4'b1000) begin n_fail++; $display("FAIL late_second: got %b want 1000", o_grant); end
        n_checks++; if (o_data !== m_data[3]) begin n_fail++; $display("FAIL late_data: got %h want %h", o_data, m_data[3]); end
        m_ptr = 3;
        pulse_free(1, 3);
        #5;
        n_checks++; if (free_cnt[1] !== f1 + 1 || free_cnt[3] !== f3 + 1) begin
            n_fail++; $display("FAIL late_frees: got ch1=%0d ch3=%0d want %0d %0d", free_cnt[1], free_cnt[3], f1 + 1, f3 + 1);
        end
    endtask

`ifdef CARB_MERGE_RR_EN
    task automatic test_round_robin();
        int exp_seq[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        int base;
        int prev;
        bit ok;
        do_reset();
        base = drv_cnt;
        pulse_drive(4'b0001, -1);
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== 4'b0001) begin n_fail++; $display("FAIL rr_seed: got %b want 0001", o_grant); end
        m_ptr = 0;
        pulse_free(1, 0);
        #4;
        base = drv_cnt;
        pulse_drive(4'b0011, -1);
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== 4'b0010) begin n_fail++; $display("FAIL rr_pair_first: got %b want 0010", o_grant); end
        m_ptr = 1;
        pulse_free(1, 1);
        wait_drv(base + 1, ok);
        n_checks++; if (!ok || o_grant !== 4'b0001) begin n_fail++; $display("FAIL rr_pair_second: got %b want 0001", o_grant); end
        m_ptr = 0;
        pulse_free(1, 0);
        #4;
        base = drv_cnt;
        prev = -1;
        pulse_drive(4'b1111, -1);
        for (int i = 0; i < 8; i++) begin
            wait_drv(base + i, ok);
            n_checks++; if (!ok || o_grant_idx !== IDX_W'(exp_seq[i])) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, o_grant_idx, exp_seq[i]);
            end
            m_ptr = exp_seq[i];
            if (prev >= 0) pulse_drive(NUM_CH'(1) << prev, -1);
            prev = exp_seq[i];
            pulse_free(1, exp_seq[i]);
        end
        while (pend_vec() != '0) begin
            int g = exp_winner();
            m_ptr = g;
            pulse_free(1, g);
        end
        #4;
    endtask
`endif

    task automatic test_reset_mid();
        int base = drv_cnt;
        int fsum = 0;
        int fsum2 = 0;
        bit ok;
        pulse_drive(4'b0100, -1);
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== 4'b0100) begin n_fail++; $display("FAIL rmid_grant: got %b want 0100", o_grant); end
        for (int k = 0; k < NUM_CH; k++) fsum += free_cnt[k];
        rstn = 1'b0;
        #1;
        n_checks++; if (o_grant !== '0) begin n_fail++; $display("FAIL rmid_grant_clr: got %b want 0", o_grant); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_clr: got %b want 0", o_busy); end
        i_freeNext = 1'b1;
        #2;
        n_checks++; if (o_free !== '0) begin n_fail++; $display("FAIL rmid_free: got %b want 0", o_free); end
        i_freeNext = 1'b0;
        #2;
        rstn = 1'b1;
        model_reset();
        #3;
        for (int k = 0; k < NUM_CH; k++) fsum2 += free_cnt[k];
        n_checks++; if (fsum2 !== fsum) begin n_fail++; $display("FAIL rmid_free_count: got %0d want %0d", fsum2, fsum); end
        base = drv_cnt;
        pulse_drive(4'b0001, -1);
        wait_drv(base, ok);
        n_checks++; if (!ok || o_grant !== 4'b0001) begin n_fail++; $display("FAIL rmid_after: got %b want 0001", o_grant); end
        n_checks++; if (o_data !== m_data[0]) begin n_fail++; $display("FAIL rmid_data: got %h want %h", o_data, m_data[0]); end
        m_ptr = 0;
        pulse_free(1, 0);
        #4;
    endtask

    task automatic test_stress();
        int req0[NUM_CH];
        int fr0[NUM_CH];
        int d_seen;
        int tx = 0;
        int g;
        bit ok;
        logic [NUM_CH-1:0] mask;
        do_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            req0[k] = req_cnt[k];
            fr0[k]  = free_cnt[k];
        end
        d_seen = drv_cnt;
        while (tx < 1000 || pend_vec() != '0) begin
            if (pend_vec() == '0) pulse_drive(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), -1);
            g = exp_winner();
            wait_drv(d_seen, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL stress_timeout: tx %0d no o_driveNext, want ch%0d", tx, g); break; end
            d_seen++;
            n_checks++; if (o_grant !== NUM_CH'(1) << g || o_grant_idx !== IDX_W'(g)) begin
                n_fail++; $display("FAIL stress_grant: tx %0d got %b/%0d want ch%0d", tx, o_grant, o_grant_idx, g);
            end
            n_checks++; if (o_data !== m_data[g]) begin n_fail++; $display("FAIL stress_data: tx %0d got %h want %h", tx, o_data, m_data[g]); end
            m_ptr = g;
            if (tx < 1000 && $urandom_range(0, 2) == 0) begin
                mask = NUM_CH'($urandom) & ~pend_vec();
                if (mask != '0) pulse_drive(mask, -1);
            end
            pulse_free($urandom_range(0, 6), g);
            tx++;
        end
        #5;
        n_checks++; if (o_grant !== '0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL stress_idle: grant %b busy %b want 0 0", o_grant, o_busy); end
        n_checks++; if (drv_cnt !== d_seen) begin n_fail++; $display("FAIL stress_drv_total: got %0d want %0d", drv_cnt, d_seen); end
        for (int k = 0; k < NUM_CH; k++) begin
            n_checks++;
            if (free_cnt[k] - fr0[k] !== req_cnt[k] - req0[k]) begin
                n_fail++; $display("FAIL stress_balance ch%0d: frees %0d want %0d", k, free_cnt[k] - fr0[k], req_cnt[k] - req0[k]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_late_arrival();
`ifdef CARB_MERGE_RR_EN
        test_round_robin();
`endif
        test_reset_mid();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
